// File: rtl/sccb_slave.sv
// SCCB responder for the OV2640 configuration path: decodes 3-phase writes, tracks the 0xFF bank register.
// Optional 2-phase read path is built when SCCB_READ_EN is defined.
module sccb_slave #(
   parameter logic [6:0] DEV_ID      = 7'h30,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sio_c,
   input  logic       i_sio_d_in,
   output logic       o_sio_d_oe,
   output logic       o_wr_valid,
   output logic       o_wr_bank,
   output logic [7:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic [7:0] o_rd_addr,
   input  logic [7:0] i_rd_data,
   output logic       o_busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK, S_DATA, S_DATA_ACK, S_WAIT_STOP
`ifdef SCCB_READ_EN
      , S_RD_BYTE, S_RD_NA
`endif
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
   logic                   r_scl_d, r_sda_d;
   logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

   state_t     r_state, w_state_next;
   logic [2:0] r_cnt, w_cnt_next;
   logic [7:0] r_shift, w_shift_next;
   logic       r_oe, w_oe_next;
   logic       r_busy, w_busy_next;
   logic       r_wr_valid, w_wr_valid_next;
   logic       r_wr_bank, w_wr_bank_next;
   logic [7:0] r_wr_addr, w_wr_addr_next;
   logic [7:0] r_wr_data, w_wr_data_next;
   logic [7:0] r_rd_addr, w_rd_addr_next;
   logic       r_bank, w_bank_next;
   logic       r_rw, w_rw_next;
   logic [7:0] w_byte;

   // Idle bus is high on both lines, so the synchronizers reset to 1 to avoid phantom edges.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_sio_c};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sio_d_in};
         r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl      = r_scl_sync[SYNC_STAGES-1];
   assign w_sda      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise = w_scl & ~r_scl_d;
   assign w_scl_fall = ~w_scl & r_scl_d;
   assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_byte     = {r_shift[6:0], w_sda};

   always_comb begin
      w_state_next    = r_state;
      w_cnt_next      = r_cnt;
      w_shift_next    = r_shift;
      w_oe_next       = r_oe;
      w_busy_next     = r_busy;
      w_wr_valid_next = 1'b0;
      w_wr_bank_next  = r_wr_bank;
      w_wr_addr_next  = r_wr_addr;
      w_wr_data_next  = r_wr_data;
      w_rd_addr_next  = r_rd_addr;
      w_bank_next     = r_bank;
      w_rw_next       = r_rw;
      if (w_start) begin
         w_state_next = S_ID;
         w_cnt_next   = 3'd0;
         w_oe_next    = 1'b0;
         w_busy_next  = 1'b1;
      end else if (w_stop) begin
         w_state_next = S_IDLE;
         w_oe_next    = 1'b0;
         w_busy_next  = 1'b0;
      end else begin
         case (r_state)
            S_ID, S_SUB, S_DATA: begin
               if (w_scl_rise) begin
                  w_shift_next = w_byte;
                  w_cnt_next   = r_cnt + 3'd1;
                  if (r_cnt == 3'd7) begin
                     case (r_state)
                        S_ID: begin
                           w_rw_next    = w_sda;
                           w_state_next = (w_byte[7:1] == DEV_ID) ? S_ID_ACK : S_WAIT_STOP;
                        end
                        S_SUB: begin
                           w_rd_addr_next = w_byte;
                           w_state_next   = S_SUB_ACK;
                        end
                        default: begin
                           w_wr_valid_next = 1'b1;
                           w_wr_addr_next  = r_rd_addr;
                           w_wr_data_next  = w_byte;
                           w_wr_bank_next  = r_bank;
                           if (r_rd_addr == 8'hFF) w_bank_next = w_byte[0];
                           w_state_next    = S_DATA_ACK;
                        end
                     endcase
                  end
               end
            end
            // First falling edge pulls the line, the next one (after the 9th clock) releases it.
            S_ID_ACK, S_SUB_ACK, S_DATA_ACK: begin
               if (w_scl_fall) begin
                  if (!r_oe) begin
                     w_oe_next = 1'b1;
                  end else begin
                     w_oe_next = 1'b0;
                     case (r_state)
                        S_ID_ACK: begin
                           if (r_rw) begin
`ifdef SCCB_READ_EN
                              w_shift_next = i_rd_data;
                              w_oe_next    = ~i_rd_data[7];
                              w_state_next = S_RD_BYTE;
`else
                              w_state_next = S_WAIT_STOP;
`endif
                           end else begin
                              w_state_next = S_SUB;
                           end
                        end
                        S_SUB_ACK: w_state_next = S_DATA;
                        default:   w_state_next = S_WAIT_STOP;
                     endcase
                  end
               end
            end
`ifdef SCCB_READ_EN
            S_RD_BYTE: begin
               if (w_scl_rise) w_cnt_next = r_cnt + 3'd1;
               if (w_scl_fall) begin
                  if (r_cnt == 3'd0) begin
                     w_oe_next    = 1'b0;
                     w_state_next = S_RD_NA;
                  end else begin
                     w_oe_next = ~r_shift[3'd7 - r_cnt];
                  end
               end
            end
            S_RD_NA: begin
               if (w_scl_rise) w_state_next = S_WAIT_STOP;
            end
`endif
            default: w_oe_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 3'd0;
         r_shift    <= 8'd0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_bank  <= 1'b0;
         r_wr_addr  <= 8'd0;
         r_wr_data  <= 8'd0;
         r_rd_addr  <= 8'd0;
         r_bank     <= 1'b0;
         r_rw       <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_shift    <= w_shift_next;
         r_oe       <= w_oe_next;
         r_busy     <= w_busy_next;
         r_wr_valid <= w_wr_valid_next;
         r_wr_bank  <= w_wr_bank_next;
         r_wr_addr  <= w_wr_addr_next;
         r_wr_data  <= w_wr_data_next;
         r_rd_addr  <= w_rd_addr_next;
         r_bank     <= w_bank_next;
         r_rw       <= w_rw_next;
      end
   end

`ifndef SCCB_READ_EN
   logic w_unused_rd;
   assign w_unused_rd = ^{i_rd_data, r_shift[7]};
`endif

   assign o_sio_d_oe = r_oe;
   assign o_wr_valid = r_wr_valid;
   assign o_wr_bank  = r_wr_bank;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_rd_addr  = r_rd_addr;
   assign o_busy     = r_busy;

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB responder (camera-side model) for the OV2640 configuration path: decodes 3-phase writes from the on-chip SCCB master and reports each register write as a one-cycle strobe.
- Tracks the OV2640 bank-select register (sub-address 0xFF), so every write is tagged with the bank it targets.
- Used as a sensor stand-in in simulation and in board loopback tests of the configuration sequencer.

Parameters:
- DEV_ID, 7'h30, 7-bit device ID; write byte 0x60, read byte 0x61.
- SYNC_STAGES, 2, synchronizer depth on sio_c and sio_d; legal values 2 or 3.

Ports:
- clk  input  1  system clock; must be at least 16x the sio_c frequency.
- rst_n  input  1  asynchronous active-low reset.
- sio_c  input  1  SCCB clock from the master.
- sio_d_in  input  1  SCCB data line, sampled value.
- sio_d_oe  output  1  1 = pull sio_d low (open drain); 0 = release.
- wr_valid  output  1  one-cycle pulse when a data byte is written.
- wr_bank  output  1  bank select (bit 0 of the 0xFF register) in effect for this write.
- wr_addr  output  8  sub-address of the write.
- wr_data  output  8  written data.
- rd_addr  output  8  current read pointer (last sub-address received).
- rd_data  input  8  read data for rd_addr; used only when SCCB_READ_EN is defined.
- busy  output  1  high from START until STOP or abort.

Behaviour:
- Reset values: sio_d_oe=0, wr_valid=0, wr_bank=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, internal bank=0, FSM in IDLE.
- Synchronization and edge detection:
  - sio_c and sio_d pass through SYNC_STAGES flops, plus one delay flop for edge detection.
  - START: sda falls while scl is high. STOP: sda rises while scl is high.
  - Detection latency is SYNC_STAGES+1 clk.
- Bit timing:
  - Data bits are sampled on the synchronized scl rising edge, MSB first.
  - Slave-driven bits (ACK, read data) change on the synchronized scl falling edge.
- FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD_BYTE, RD_NA, WAIT_STOP.
  - IDLE -> ID on START. In any state, START returns to ID (repeated start), and STOP returns to IDLE and clears busy.
  - ID: shift 8 bits. If byte[7:1]==DEV_ID, go to ID_ACK. Otherwise go to WAIT_STOP with sio_d_oe held 0.
  - ID_ACK: drive sio_d_oe=1 from the falling edge after bit 8 to the falling edge after the 9th clock.
    - R/W=0: go to SUB.
    - R/W=1: go to RD_BYTE if SCCB_READ_EN is defined, else WAIT_STOP.
  - SUB: shift 8 bits into rd_addr (updated at the 8th rising edge), then SUB_ACK (same ACK timing as ID_ACK), then DATA.
  - STOP after SUB_ACK is a 2-phase write: rd_addr is kept and wr_valid does not fire.
  - DATA: shift 8 bits; on the 8th rising edge:
    - wr_valid pulses for exactly 1 clk with wr_addr=rd_addr, wr_data=byte, wr_bank=bank as it was before this write.
    - If rd_addr==0xFF, bank <= byte[0] in the same cycle.
    - Then DATA_ACK -> WAIT_STOP. Further bytes before STOP are ignored and no auto-increment is performed.
  - RD_BYTE: load rd_data at the ID_ACK release edge.
    - Drive sio_d_oe = ~bit on each falling edge, MSB first.
    - Release after the 8th bit, then go to RD_NA.
  - RD_NA: master NA bit; no drive, no check. Then WAIT_STOP.
- Bit counter: 3 bits, wraps 7->0 at each byte boundary; cleared on START.
- sio_d_oe is forced to 0 in IDLE and WAIT_STOP, and on any START or STOP.
- An scl pulse with no preceding START is ignored.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). The bus is released and bank is cleared to 0.

Optional Feature:
- SCCB_READ_EN defined: the 2-phase read path (RD_BYTE, RD_NA) is built; a matched ID with R/W=1 is acknowledged and rd_data is returned.
- SCCB_READ_EN undefined: RD_BYTE and RD_NA are not built, the rd_data input is unused, and a read ID still gets ACK (so the master does not hang) but goes to WAIT_STOP; the line stays released.

Test Plan:
- Write 0x60,0xFF,0x01 then STOP; write 0x60,0x12,0x80 then STOP -> two wr_valid pulses: (bank0,0xFF,0x01), then (bank1,0x12,0x80); three ACK lows per transaction.
- Write with ID 0x42 -> sio_d_oe never asserts, no wr_valid, busy drops at STOP.
- 0x60,0x0A then STOP, then 0x61 read with rd_data=0x26 (SCCB_READ_EN) -> rd_addr=0x0A, sio_d_oe pattern equals ~0x26 MSB first, released during NA; without the macro the line stays released after the ID ACK.
- Repeated START after the SUB byte, followed by a full write 0x60,0x11,0x01 -> a single wr_valid (bank per prior state, 0x11, 0x01); the aborted transaction produces nothing.
- rst_n low mid DATA byte with bank=1 -> immediate release, bank=0, busy=0; the next write 0x60,0x3C,0x32 reports bank 0.
- Four data bytes after one sub-address -> exactly one wr_valid, carrying the first byte.
